// File: rtl/data_memory_responder_if.sv
// Load/store port between the core datapath and the data-memory responder.
// The master side is the core, the slave side is the responder.
interface data_memory_responder_if #(
    parameter int WORDSIZE = 64
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [WORDSIZE-1:0] req_addr;
    logic [WORDSIZE-1:0] req_wdata;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic                resp_valid;
    logic                resp_ready;
    logic [WORDSIZE-1:0] resp_rdata;
    logic                resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency data-memory responder: one outstanding byte-addressed RV64 load/store,
// little-endian, with alignment/range checking and sign/zero extension of loads.
module data_memory_responder #(
    parameter int WORDSIZE   = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    data_memory_responder_if.slave  bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [WORDSIZE-1:0] r_addr;
    logic [WORDSIZE-1:0] r_wdata;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [WORDSIZE-1:0] r_rdata;
    logic                r_error;
    logic [WORDSIZE-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_err;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [5:0]            w_shamt;
    logic [WORDSIZE-1:0]   w_rd_word;
    logic [WORDSIZE-1:0]   w_rd_shifted;
    logic [WORDSIZE-1:0]   w_wdata_shifted;
    logic [7:0]            w_byte_mask;
    logic [WORDSIZE-1:0]   w_bit_mask;
    logic [WORDSIZE-1:0]   w_new_word;

    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            2'd3:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic size_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off[2:0];
            default: return 1'b1;
        endcase
    endfunction

    // Raw data is already shifted down so the addressed bytes sit at bit 0.
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                                input logic uns);
        case (size)
            2'd0:    return uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    return uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    return uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            2'd3:    return raw;
            default: return 64'd0;
        endcase
    endfunction

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;

    // Access decode from the captured request: checks, byte lanes and merged store word.
    always_comb begin
        w_accept        = (r_state == ST_IDLE) && bus.req_valid;
        w_commit        = (r_state == ST_WAIT) && (r_cnt == '0);
        w_misaligned    = size_misaligned(r_size, r_addr[2:0]);
        w_out_of_range  = |r_addr[WORDSIZE-1:ADDR_WIDTH+3];
        w_err           = w_misaligned || w_out_of_range;
        w_mem_we        = w_commit && r_write && !w_err;
        w_word_idx      = r_addr[ADDR_WIDTH+2:3];
        w_shamt         = {r_addr[2:0], 3'b000};
        w_rd_word       = r_mem[w_word_idx];
        w_rd_shifted    = w_rd_word >> w_shamt;
        w_wdata_shifted = r_wdata << w_shamt;
        w_byte_mask     = size_byte_mask(r_size) << r_addr[2:0];
        w_bit_mask      = '0;
        for (int b = 0; b < 8; b++) begin
            w_bit_mask[8*b +: 8] = {8{w_byte_mask[b]}};
        end
        w_new_word      = (w_rd_word & ~w_bit_mask) | (w_wdata_shifted & w_bit_mask);
    end

    // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) w_state_nxt = ST_WAIT;
                else               w_state_nxt = ST_IDLE;
            end
            ST_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_RESP;
                else             w_state_nxt = ST_WAIT;
            end
            ST_RESP: begin
                if (bus.resp_ready) w_state_nxt = ST_IDLE;
                else                w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, request capture, latency counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_resp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_cnt      <= CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_error <= w_err;
                r_rdata <= (w_err || r_write) ? '0
                                              : extend_load(w_rd_shifted, r_size, r_unsigned);
            end
        end
    end

    // Storage array; contents survive reset, writes gated to the commit edge in WAIT.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_word_idx] <= w_new_word;
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder against a byte-array reference model.
module tb_data_memory_responder;
    localparam int LAT       = 2;
    localparam int AW        = 10;
    localparam int MEM_BYTES = 1 << (AW + 3);

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] m_mem [0:MEM_BYTES-1];

    always #5 clk = ~clk;

    data_memory_responder_if #(.WORDSIZE(64)) mem_bus ();

    data_memory_responder #(.WORDSIZE(64), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mem_bus)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    // Reference: little-endian byte array, alignment = address multiple of access size.
    task automatic model_access(input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [63:0] rd, output logic err);
        int nb;
        logic [63:0] v;
        nb  = 1 << size;
        err = (addr >= 64'(MEM_BYTES)) || ((addr % 64'(nb)) != 64'd0);
        rd  = 64'd0;
        if (!err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) m_mem[int'(addr[12:0]) + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[int'(addr[12:0]) + i];
                if (nb < 8 && !uns && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
                rd = v;
            end
        end
    endtask

    task automatic dut_access(input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [1:0] size, input logic uns, input int hold,
                              output logic [63:0] rd, output logic err);
        int n;
        @(negedge clk);
        check_val("req_ready_idle", 64'(mem_bus.req_ready), 64'd1);
        mem_bus.req_valid    = 1'b1;
        mem_bus.req_write    = w;
        mem_bus.req_addr     = addr;
        mem_bus.req_wdata    = wdata;
        mem_bus.req_size     = size;
        mem_bus.req_unsigned = uns;
        @(posedge clk);
        #1;
        mem_bus.req_valid    = 1'b0;
        mem_bus.req_write    = 1'($urandom);
        mem_bus.req_addr     = {$urandom, $urandom};
        mem_bus.req_wdata    = {$urandom, $urandom};
        mem_bus.req_size     = 2'($urandom);
        mem_bus.req_unsigned = 1'($urandom);
        check_val("req_ready_busy", 64'(mem_bus.req_ready), 64'd0);
        n = 0;
        while (!mem_bus.resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("latency", 64'(n), 64'(LAT));
        rd  = mem_bus.resp_rdata;
        err = mem_bus.resp_error;
        if (!mem_bus.resp_valid) return;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", 64'(mem_bus.resp_valid), 64'd1);
            check_val("hold_rdata", mem_bus.resp_rdata, rd);
            check_val("hold_error", 64'(mem_bus.resp_error), 64'(err));
            check_val("hold_req_ready", 64'(mem_bus.req_ready), 64'd0);
        end
        mem_bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_bus.resp_ready = 1'b0;
        check_val("req_ready_return", 64'(mem_bus.req_ready), 64'd1);
        check_val("resp_valid_drop", 64'(mem_bus.resp_valid), 64'd0);
    endtask

    task automatic run_and_check(input string tag, input logic w, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [1:0] size,
                                 input logic uns, input int hold, output logic [63:0] rd);
        logic [63:0] exp_rd;
        logic        exp_err;
        logic        err;
        model_access(w, addr, wdata, size, uns, exp_rd, exp_err);
        dut_access(w, addr, wdata, size, uns, hold, rd, err);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_error"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] addr;
        rst_n                = 1'b0;
        mem_bus.req_valid    = 1'b0;
        mem_bus.req_write    = 1'b0;
        mem_bus.req_addr     = 64'd0;
        mem_bus.req_wdata    = 64'd0;
        mem_bus.req_size     = 2'd0;
        mem_bus.req_unsigned = 1'b0;
        mem_bus.resp_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", 64'(mem_bus.req_ready), 64'd1);
        check_val("rst_resp_valid", 64'(mem_bus.resp_valid), 64'd0);
        check_val("rst_rdata", mem_bus.resp_rdata, 64'd0);
        check_val("rst_error", 64'(mem_bus.resp_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_and_check("t1_st", 1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, 0, rd);
        run_and_check("t1_ld", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd);
        check_val("t1_const", rd, 64'h1122334455667788);

        run_and_check("t2_st", 1'b1, 64'h13, 64'h80, 2'd0, 1'b0, 0, rd);
        run_and_check("t2_lds", 1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 0, rd);
        check_val("t2_signed", rd, 64'hFFFFFFFFFFFFFF80);
        run_and_check("t2_ldu", 1'b0, 64'h13, 64'd0, 2'd0, 1'b1, 0, rd);
        check_val("t2_unsigned", rd, 64'h0000000000000080);
        run_and_check("t2_ldd", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd);
        check_val("t2_dword", rd, 64'h1122334480667788);

        run_and_check("t3_ldw", 1'b0, 64'h12, 64'd0, 2'd2, 1'b0, 0, rd);
        run_and_check("t3_sth", 1'b1, 64'h11, 64'hFFFF, 2'd1, 1'b0, 0, rd);
        run_and_check("t3_ldd", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd);
        check_val("t3_unchanged", rd, 64'h1122334480667788);

        run_and_check("t4_oor_ld", 1'b0, 64'd1 << (AW + 3), 64'd0, 2'd3, 1'b0, 0, rd);
        run_and_check("t4_oor_st", 1'b1, (64'd1 << (AW + 3)) | 64'h10, 64'hDEAD, 2'd3, 1'b0, 0, rd);

        run_and_check("t5_hold", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 5, rd);
        check_val("t5_const", rd, 64'h1122334480667788);

        // Store accepted, then reset during WAIT before the commit edge.
        @(negedge clk);
        mem_bus.req_valid = 1'b1;
        mem_bus.req_write = 1'b1;
        mem_bus.req_addr  = 64'h10;
        mem_bus.req_wdata = 64'hDEADBEEFCAFEF00D;
        mem_bus.req_size  = 2'd3;
        @(posedge clk);
        #1;
        mem_bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t6_req_ready", 64'(mem_bus.req_ready), 64'd1);
        check_val("t6_resp_valid", 64'(mem_bus.resp_valid), 64'd0);
        check_val("t6_rdata", mem_bus.resp_rdata, 64'd0);
        check_val("t6_error", 64'(mem_bus.resp_error), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_and_check("t6_ld", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 0, rd);
        check_val("t6_old_data", rd, 64'h1122334480667788);

        for (int wd = 0; wd < 16; wd++) begin
            run_and_check("init", 1'b1, 64'(wd * 8), {$urandom, $urandom}, 2'd3, 1'b0, 0, rd);
        end

        for (int t = 0; t < 300; t++) begin
            addr = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) addr = (64'd1 << $urandom_range(AW + 3, 63)) | addr;
            run_and_check("rand", 1'($urandom), addr, {$urandom, $urandom}, 2'($urandom),
                          1'($urandom), int'($urandom_range(0, 3)), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
